keccak_byte_packer: RTL
=======================

KECCAK_BYTE_PACKER -- requirements
Module: keccak_byte_packer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 byte_in  input  8  message byte from upstream.
REQ-005 byte_valid  input  1  byte_in valid.
REQ-006 byte_last  input  1  byte_in is final byte of message; qualified by byte_valid.
REQ-007 byte_ready  output  1  packer accepts byte this cycle; transfer = byte_valid & byte_ready.
REQ-008 core_reset  output  1  one-cycle reset pulse to keccak core at message start.
REQ-009 k_in  output  32  word to core, first byte in bits [31:24].
REQ-010 k_in_ready  output  1  k_in valid.
REQ-011 k_is_last  output  1  k_in is final word of message.
REQ-012 k_byte_num  output  2  count of valid bytes in final word (0..3).
REQ-013 buffer_full  input  1  core cannot take a word; word transfer = k_in_ready & ~buffer_full.
REQ-014 out_ready  input  1  core digest valid.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, CLR, PACK, FINAL, WAIT.
REQ-017 IDLE: byte_ready=0; byte_valid=1 -> CLR next cycle.
REQ-018 CLR: core_reset=1 for exactly this one cycle, byte_ready=0 -> PACK.
REQ-019 PACK: accumulator acc (24 bits) + count acc_cnt (0..3) + one holding word (hold_valid, data, last, bnum).
REQ-020 Accepted byte with acc_cnt<3 and not last: shift into acc, acc_cnt+1.
REQ-021 Accepted 4th byte, not last: hold <= {acc,byte}, last=0, bnum=0; acc_cnt=0.
REQ-022 Accepted last byte making n=1..3 bytes: hold <= bytes MSB-aligned, unused low bytes 0, last=1, bnum=n; -> FINAL.
REQ-023 Accepted last byte making 4 bytes: hold <= full word, last=0; then an extra word 0x00000000, last=1, bnum=0, loaded into hold when hold frees; -> FINAL.
REQ-024 byte_ready SHALL be 1 in PACK except when acc_cnt==3 and hold_valid and no word transfer this cycle (combinational on buffer_full).
REQ-025 Hold SHALL load in the cycle of its draining transfer when needed (back-to-back words, no bubble); 1 byte/cycle sustained when buffer_full=0.
REQ-026 Latency: word appears on k_in/k_in_ready the cycle after its completing byte is accepted.
REQ-027 k_in, k_is_last, k_byte_num SHALL equal hold contents when k_in_ready=1 and be 0 otherwise.
REQ-028 FINAL: byte_ready=0; after transfer of the last=1 word -> WAIT.
REQ-029 WAIT: byte_ready=0; out_ready=1 -> IDLE next cycle; bytes presented during WAIT are held off, not dropped.
REQ-030 Word order SHALL equal byte arrival order; no word duplicated or lost under any buffer_full pattern.
REQ-031 Zero-length messages are unsupported; every message SHALL contain at least one byte with byte_last.

Reset
REQ-032 reset=1 SHALL immediately force: state IDLE, acc_cnt=0, hold_valid=0, byte_ready=0, core_reset=0, k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, busy=0.
REQ-033 reset mid-message SHALL discard all partial data; next message starts from IDLE with a fresh CLR pulse.

Verification
REQ-034 "abc" ('c' last), buffer_full=0 -> core_reset pulse, then one word 0x61626300, k_is_last=1, k_byte_num=3, then WAIT.
REQ-035 "Hell" ('l' last) -> word 0x48656C6C last=0, next cycle 0x00000000 last=1 byte_num=0.
REQ-036 "Hello, w" streamed with buffer_full=1 for cycles 3-7 -> byte_ready drops only at acc_cnt==3 with hold full; words 0x48656C6C, 0x6F2C2077 delivered in order, then 0x00000000 last=1.
REQ-037 byte_valid held high in WAIT -> byte_ready=0 until out_ready=1; then IDLE, CLR pulse, new message packs correctly.
REQ-038 reset asserted after 2 bytes of a message -> all outputs 0 in same cycle; following "xyz" message yields 0x78797A00 byte_num=3 last=1.
REQ-039 12-byte message, buffer_full=0 -> 3 full words on consecutive cycles with no bubble, then 0x00000000 last=1.

Source files
------------

// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer: packs a byte stream into 32-bit big-endian words for a keccak core
module keccak_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        core_reset,
    output logic [31:0] k_in,
    output logic        k_in_ready,
    output logic        k_is_last,
    output logic [1:0]  k_byte_num,
    input  logic        buffer_full,
    input  logic        out_ready,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, CLR, PACK, FINAL, WAIT} state_t;
    state_t      r_state;
    logic [23:0] r_acc;
    logic [1:0]  r_cnt;
    logic        r_hv;
    logic [31:0] r_hdata;
    logic        r_hlast;
    logic [1:0]  r_hbnum;
    logic        r_pv;
    logic [31:0] r_pdata;
    logic [1:0]  r_pbnum;
    logic        w_xfer;
    logic        w_free;
    logic        w_take;
    logic [31:0] w_word;
    assign w_xfer     = r_hv & ~buffer_full;
    assign w_free     = ~r_hv | w_xfer;
    assign byte_ready = (r_state == PACK) & ~((r_cnt == 2'd3) & ~w_free);
    assign w_take     = byte_valid & byte_ready;
    // accumulated bytes plus the incoming one, pushed up so the first byte lands in [31:24]
    assign w_word     = {r_acc, byte_in} << {2'd3 - r_cnt, 3'd0};
    assign core_reset = r_state == CLR;
    assign busy       = r_state != IDLE;
    assign k_in_ready = r_hv;
    assign k_in       = r_hv ? r_hdata : 32'd0;
    assign k_is_last  = r_hv & r_hlast;
    assign k_byte_num = r_hv ? r_hbnum : 2'd0;
    // control FSM with byte accumulator, output holding word and a pending final word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hv    <= 1'b0;
            r_hdata <= '0;
            r_hlast <= 1'b0;
            r_hbnum <= '0;
            r_pv    <= 1'b0;
            r_pdata <= '0;
            r_pbnum <= '0;
        end else begin
            if (w_xfer) r_hv <= 1'b0;
            case (r_state)
                IDLE: if (byte_valid) r_state <= CLR;
                CLR: begin
                    r_state <= PACK;
                    r_cnt   <= '0;
                    r_hv    <= 1'b0;
                    r_pv    <= 1'b0;
                end
                PACK: if (w_take) begin
                    if (byte_last) begin
                        r_state <= FINAL;
                        r_cnt   <= '0;
                        if (r_cnt == 2'd3) begin
                            r_hv    <= 1'b1;
                            r_hdata <= w_word;
                            r_hlast <= 1'b0;
                            r_hbnum <= 2'd0;
                            r_pv    <= 1'b1;
                            r_pdata <= 32'd0;
                            r_pbnum <= 2'd0;
                        end else if (w_free) begin
                            r_hv    <= 1'b1;
                            r_hdata <= w_word;
                            r_hlast <= 1'b1;
                            r_hbnum <= r_cnt + 2'd1;
                        end else begin
                            r_pv    <= 1'b1;
                            r_pdata <= w_word;
                            r_pbnum <= r_cnt + 2'd1;
                        end
                    end else if (r_cnt == 2'd3) begin
                        r_hv    <= 1'b1;
                        r_hdata <= w_word;
                        r_hlast <= 1'b0;
                        r_hbnum <= 2'd0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= {r_acc[15:0], byte_in};
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                FINAL: begin
                    if (r_pv & w_free) begin
                        r_hv    <= 1'b1;
                        r_hdata <= r_pdata;
                        r_hlast <= 1'b1;
                        r_hbnum <= r_pbnum;
                        r_pv    <= 1'b0;
                    end
                    if (w_xfer & r_hlast) r_state <= WAIT;
                end
                WAIT: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
